// File: rtl/servo_pkg.sv
// Shared instruction format, clamp defaults and FSM encodings for the servo command scheduler.
package servo_pkg;

  localparam int unsigned INSTR_W     = 10;
  localparam int unsigned CH_FIELD_W  = 2;
  localparam int unsigned POS_FIELD_W = 8;

  localparam int unsigned CENTER  = 128;
  localparam int unsigned MIN_POS = 10;
  localparam int unsigned MAX_POS = 245;

  typedef struct packed {
    logic [CH_FIELD_W-1:0]  ch;
    logic [POS_FIELD_W-1:0] pos;
  } instr_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REARM    = 2'd1,
    WAIT_LOW = 2'd2
  } cap_state_e;

  typedef enum logic {
    A_IDLE  = 1'b0,
    A_DRAIN = 1'b1
  } app_state_e;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous first-word-fall-through command queue; head entry is visible on rdata while not empty.
module cmd_fifo #(
  parameter int unsigned DATA_W = 10,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     pop,
  output logic [DATA_W-1:0]        rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_q, wr_d;
  logic [PTR_W-1:0]  rd_q, rd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              do_push;
  logic              do_pop;

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign rdata   = mem_q[rd_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + PTR_W'(1);
    if (do_pop)  rd_d = rd_q + PTR_W'(1);
    // Simultaneous push and pop leaves occupancy unchanged.
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata;
  end

endmodule

// File: rtl/servo_cmd_sched.sv
// Captures serial servo instructions into a queue and applies them to per-channel
// position registers in a burst at each PWM frame boundary.
module servo_cmd_sched #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned POS_W      = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MIN_POS    = servo_pkg::MIN_POS,
  parameter int unsigned MAX_POS    = servo_pkg::MAX_POS,
  parameter int unsigned CENTER     = servo_pkg::CENTER
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         instr_ready,
  input  logic [servo_pkg::INSTR_W-1:0] instr,
  output logic                         rx_rearm,
  input  logic                         frame_start,
  output logic [NUM_CH*POS_W-1:0]      pos_out,
  output logic [NUM_CH-1:0]            update_strobe,
  output logic                         fifo_full,
  output logic                         busy,
  output logic [7:0]                   drop_count
);

  localparam int unsigned CH_W    = servo_pkg::CH_FIELD_W;
  localparam int unsigned ENTRY_W = CH_W + POS_W;
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;

  servo_pkg::instr_t     instr_s;
  servo_pkg::cap_state_e cap_q, cap_d;
  servo_pkg::app_state_e app_q, app_d;

  logic [POS_W-1:0]        pos_clamped;
  logic                    push, drop, pop;
  logic [ENTRY_W-1:0]      fifo_rdata;
  logic                    fifo_empty;
  logic [CNT_W-1:0]        fifo_count;
  logic [CH_W-1:0]         head_ch;
  logic [POS_W-1:0]        head_pos;

  logic [CNT_W-1:0]        snap_q, snap_d;
  logic [7:0]              drop_q, drop_d;
  logic [NUM_CH*POS_W-1:0] pos_q, pos_d;
  logic [NUM_CH-1:0]       strobe_q, strobe_d;
  logic                    rearm_q, rearm_d;
  logic                    busy_q, busy_d;

  assign instr_s  = servo_pkg::instr_t'(instr);
  assign head_ch  = fifo_rdata[ENTRY_W-1 -: CH_W];
  assign head_pos = fifo_rdata[POS_W-1:0];

  // Clamp the raw position field into the mechanical limits.
  always_comb begin
    pos_clamped = POS_W'(instr_s.pos);
    if (32'(instr_s.pos) < MIN_POS)      pos_clamped = POS_W'(MIN_POS);
    else if (32'(instr_s.pos) > MAX_POS) pos_clamped = POS_W'(MAX_POS);
  end

  cmd_fifo #(
    .DATA_W (ENTRY_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata ({instr_s.ch, pos_clamped}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Capture FSM: one push or drop per instruction, then rearm and wait for ready to fall.
  always_comb begin
    cap_d  = cap_q;
    push   = 1'b0;
    drop   = 1'b0;
    drop_d = drop_q;
    case (cap_q)
      servo_pkg::IDLE: begin
        if (instr_ready) begin
          if (fifo_full) drop = 1'b1;
          else           push = 1'b1;
          cap_d = servo_pkg::REARM;
        end
      end
      servo_pkg::REARM:    cap_d = servo_pkg::WAIT_LOW;
      servo_pkg::WAIT_LOW: if (!instr_ready) cap_d = servo_pkg::IDLE;
      default:             cap_d = servo_pkg::IDLE;
    endcase
    if (drop && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
    rearm_d = (cap_d == servo_pkg::REARM);
  end

  // Apply FSM: drain only the entries present at the frame boundary.
  always_comb begin
    app_d    = app_q;
    snap_d   = snap_q;
    pop      = 1'b0;
    pos_d    = pos_q;
    strobe_d = '0;
    case (app_q)
      servo_pkg::A_IDLE: begin
        if (frame_start) begin
          snap_d = fifo_count;
          if (fifo_count != '0) app_d = servo_pkg::A_DRAIN;
        end
      end
      servo_pkg::A_DRAIN: begin
        pop    = !fifo_empty;
        snap_d = snap_q - CNT_W'(1);
        if (snap_q <= CNT_W'(1)) app_d = servo_pkg::A_IDLE;
      end
      default: app_d = servo_pkg::A_IDLE;
    endcase
    if (pop) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (int'(head_ch) == c) begin
          pos_d[c*POS_W +: POS_W] = head_pos;
          strobe_d[c]             = 1'b1;
        end
      end
    end
    busy_d = (app_d == servo_pkg::A_DRAIN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cap_q    <= servo_pkg::IDLE;
      app_q    <= servo_pkg::A_IDLE;
      snap_q   <= '0;
      drop_q   <= '0;
      pos_q    <= {NUM_CH{POS_W'(CENTER)}};
      strobe_q <= '0;
      rearm_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      cap_q    <= cap_d;
      app_q    <= app_d;
      snap_q   <= snap_d;
      drop_q   <= drop_d;
      pos_q    <= pos_d;
      strobe_q <= strobe_d;
      rearm_q  <= rearm_d;
      busy_q   <= busy_d;
    end
  end

  assign pos_out       = pos_q;
  assign update_strobe = strobe_q;
  assign rx_rearm      = rearm_q;
  assign busy          = busy_q;
  assign drop_count    = drop_q;

endmodule

// File: tb/tb_servo_cmd_sched.sv
// Directed bench for servo_cmd_sched: capture handshake, clamping, queue overflow,
// frame-synchronous draining and reset during a drain.
module tb_servo_cmd_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        instr_ready = 1'b0;
  logic [9:0]  instr = '0;
  logic        rx_rearm;
  logic        frame_start = 1'b0;
  logic [31:0] pos_out;
  logic [3:0]  update_strobe;
  logic        fifo_full;
  logic        busy;
  logic [7:0]  drop_count;

  int n_checks = 0;
  int n_pass   = 0;
  int rearm_cnt;

  servo_cmd_sched dut (
    .clk           (clk),
    .reset         (reset),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .rx_rearm      (rx_rearm),
    .frame_start   (frame_start),
    .pos_out       (pos_out),
    .update_strobe (update_strobe),
    .fifo_full     (fifo_full),
    .busy          (busy),
    .drop_count    (drop_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic logic [7:0] pos_of(input int c);
    return pos_out[c*8 +: 8];
  endfunction

  // Receiver model: ready held three cycles, then low until the FSM is back in IDLE.
  task automatic send(input logic [1:0] ch, input logic [7:0] p);
    instr       = {ch, p};
    instr_ready = 1'b1;
    repeat (3) tick();
    instr_ready = 1'b0;
    repeat (2) tick();
  endtask

  task automatic frame_pulse();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  initial begin
    repeat (2) tick();
    reset = 1'b0;
    chk("rst_pos",    pos_out, 32'h8080_8080);
    chk("rst_strobe", 32'(update_strobe), 0);
    chk("rst_rearm",  32'(rx_rearm), 0);
    chk("rst_busy",   32'(busy), 0);
    chk("rst_full",   32'(fifo_full), 0);
    chk("rst_drop",   32'(drop_count), 0);

    // Single instruction, ready held 5 cycles
    instr       = 10'b01_1010_0000;
    instr_ready = 1'b1;
    tick();
    chk("t1_rearm_pulse", 32'(rx_rearm), 1);
    rearm_cnt = int'(rx_rearm);
    repeat (4) begin
      tick();
      rearm_cnt += int'(rx_rearm);
    end
    instr_ready = 1'b0;
    tick();
    rearm_cnt += int'(rx_rearm);
    tick();
    chk("t1_rearm_count", 32'(rearm_cnt), 1);
    chk("t1_no_early_apply", 32'(pos_of(1)), 128);
    frame_pulse();
    chk("t1_busy", 32'(busy), 1);
    tick();
    chk("t1_pos_ch1", 32'(pos_of(1)), 160);
    chk("t1_strobe",  32'(update_strobe), 32'h2);
    chk("t1_busy_done", 32'(busy), 0);
    tick();
    chk("t1_strobe_off", 32'(update_strobe), 0);

    // Clamping at both limits
    send(2'd0, 8'd3);
    send(2'd3, 8'd250);
    frame_pulse();
    tick();
    chk("t2_pos_ch0", 32'(pos_of(0)), 10);
    chk("t2_strobe0", 32'(update_strobe), 32'h1);
    chk("t2_busy_mid", 32'(busy), 1);
    tick();
    chk("t2_pos_ch3", 32'(pos_of(3)), 245);
    chk("t2_strobe3", 32'(update_strobe), 32'h8);
    chk("t2_busy_done", 32'(busy), 0);

    // Overflow: six commands, four fit
    send(2'd0, 8'd20);
    send(2'd1, 8'd30);
    send(2'd2, 8'd40);
    chk("t3_not_full", 32'(fifo_full), 0);
    send(2'd3, 8'd50);
    chk("t3_full", 32'(fifo_full), 1);
    send(2'd0, 8'd60);
    send(2'd1, 8'd70);
    chk("t3_drops", 32'(drop_count), 2);
    frame_pulse();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t3_busy_%0d", i), 32'(busy), 1);
      tick();
      chk($sformatf("t3_strobe_%0d", i), 32'(update_strobe), 32'(1 << i));
      chk($sformatf("t3_pos_%0d", i), 32'(pos_of(i)), 32'(20 + 10 * i));
    end
    chk("t3_busy_done", 32'(busy), 0);
    chk("t3_full_cleared", 32'(fifo_full), 0);

    // Drop counter saturation
    for (int i = 0; i < 4; i++) send(2'd2, 8'(100 + i));
    for (int i = 0; i < 300; i++) send(2'd2, 8'd200);
    chk("t4_drop_sat", 32'(drop_count), 255);
    chk("t4_full", 32'(fifo_full), 1);
    frame_pulse();
    repeat (4) tick();
    chk("t4_last_wins", 32'(pos_of(2)), 103);
    chk("t4_busy_done", 32'(busy), 0);

    // Push during drain waits for the next frame; frame_start ignored while draining
    send(2'd0, 8'd50);
    send(2'd1, 8'd60);
    frame_start = 1'b1;
    tick();
    chk("t5_busy", 32'(busy), 1);
    instr       = {2'd3, 8'd200};
    instr_ready = 1'b1;
    tick();
    chk("t5_pos_ch0", 32'(pos_of(0)), 50);
    chk("t5_strobe0", 32'(update_strobe), 32'h1);
    tick();
    chk("t5_pos_ch1", 32'(pos_of(1)), 60);
    chk("t5_busy_done", 32'(busy), 0);
    frame_start = 1'b0;
    instr_ready = 1'b0;
    repeat (2) tick();
    chk("t5_held_ch3", 32'(pos_of(3)), 50);
    chk("t5_no_strobe", 32'(update_strobe), 0);
    chk("t5_idle", 32'(busy), 0);
    frame_pulse();
    chk("t5_busy2", 32'(busy), 1);
    tick();
    chk("t5_pos_ch3", 32'(pos_of(3)), 200);
    chk("t5_strobe3", 32'(update_strobe), 32'h8);

    // Reset in the second drain cycle of a three-entry snapshot
    tick();
    send(2'd0, 8'd70);
    send(2'd1, 8'd80);
    send(2'd2, 8'd90);
    frame_pulse();
    tick();
    chk("t6_first_pop", 32'(pos_of(0)), 70);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_pos_center", pos_out, 32'h8080_8080);
    chk("t6_strobe", 32'(update_strobe), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_drop", 32'(drop_count), 0);
    chk("t6_full", 32'(fifo_full), 0);
    tick();
    frame_pulse();
    chk("t6_empty_no_drain", 32'(busy), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("t6_quiet_%0d", i), 32'(update_strobe), 0);
    end
    chk("t6_ch1_center", 32'(pos_of(1)), 128);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/servo_cmd_sched.md
SERVO_CMD_SCHED -- requirements
Module: servo_cmd_sched

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, meaning number of servo channels (instruction channel field is 2 bits).
REQ-002 The block SHALL have parameter POS_W, default 8, meaning position field width.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4, meaning command queue entries (power of 2).
REQ-004 The block SHALL have parameters MIN_POS, default 10, and MAX_POS, default 245, meaning clamp limits; and CENTER, default 128, meaning reset position.
REQ-005 The block SHALL have port clk  in  1  clock.
REQ-006 The block SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-007 The block SHALL have port instr_ready  in  1  receiver has a complete instruction; held high until the receiver is rearmed.
REQ-008 The block SHALL have port instr  in  10  instruction word: [9:8] channel, [7:0] position.
REQ-009 The block SHALL have port rx_rearm  out  1  one-cycle pulse that resets the serial receiver for the next word.
REQ-010 The block SHALL have port frame_start  in  1  one-cycle pulse at each 20 ms PWM frame boundary.
REQ-011 The block SHALL have port pos_out  out  NUM_CH*POS_W  per-channel position; channel c occupies bits [c*POS_W +: POS_W].
REQ-012 The block SHALL have port update_strobe  out  NUM_CH  one-cycle pulse on the channel whose pos_out just changed.
REQ-013 The block SHALL have ports fifo_full  out  1, busy  out  1 (apply window open), and drop_count  out  8 (saturating count of dropped commands).

Function
REQ-014 The capture FSM SHALL have states IDLE, REARM, WAIT_LOW.
REQ-015 In IDLE, at an edge sampling instr_ready=1, the block SHALL push {channel, clamped position} to the FIFO, or drop it if full, and move to REARM.
REQ-016 rx_rearm SHALL be high exactly one cycle, in the cycle after the capture edge (REARM), then the FSM moves to WAIT_LOW.
REQ-017 WAIT_LOW SHALL return to IDLE only at an edge sampling instr_ready=0; one instruction is never captured twice.
REQ-018 The position SHALL be clamped: below MIN_POS becomes MIN_POS, above MAX_POS becomes MAX_POS, otherwise unchanged.
REQ-019 A dropped command SHALL increment drop_count, which saturates at 255 and never wraps.
REQ-020 The apply FSM SHALL have states A_IDLE and A_DRAIN.
REQ-021 At frame_start in A_IDLE, the block SHALL snapshot the FIFO occupancy into a count. It SHALL enter A_DRAIN if the count is nonzero; otherwise it SHALL stay in A_IDLE.
REQ-022 In A_DRAIN, the block SHALL pop one entry per cycle, write pos_out[ch], pulse update_strobe[ch] in the same cycle as the write, and decrement the count.
REQ-023 The block SHALL return to A_IDLE after the last entry in the snapshot is popped.
REQ-024 Entries pushed during A_DRAIN SHALL wait for the next frame_start.
REQ-025 busy SHALL equal (state==A_DRAIN).
REQ-026 frame_start SHALL be ignored while in A_DRAIN.
REQ-027 Multiple commands for one channel in one frame SHALL be applied in FIFO order; the last one wins and each one strobes.
REQ-028 A simultaneous push and pop SHALL leave the occupancy unchanged. fifo_full SHALL be computed from occupancy before the push.
REQ-029 Channel field values at or above NUM_CH SHALL be popped without any write or strobe.

Reset
REQ-030 Reset SHALL set pos_out to CENTER on all channels and update_strobe, rx_rearm and busy to 0.
REQ-031 Reset SHALL set drop_count to 0, empty the FIFO, and put both FSMs in IDLE/A_IDLE.
REQ-032 Reset SHALL override all other inputs in the same cycle; a reset during A_DRAIN SHALL discard the remaining snapshot.

Structure
REQ-033 Package servo_pkg SHALL hold INSTR_W=10, the channel and position field bounds, CENTER, MIN_POS, MAX_POS, and the FSM state encodings.
REQ-034 The FIFO SHALL be a sub-module cmd_fifo: synchronous, with push, pop, full, empty and count outputs, and first-word-fall-through.

Verification
REQ-035 The bench SHALL cover: instr=10'b01_1010_0000, instr_ready held 5 cycles -> exactly one push and a one-cycle rx_rearm; at the next frame_start, pos_out[ch1]=160 and update_strobe=4'b0010.
REQ-036 The bench SHALL cover: instr position 3 on ch0 and position 250 on ch3 -> applied values 10 and 245.
REQ-037 The bench SHALL cover: 6 commands with no frame_start -> fifo_full after the 4th, drop_count=2; the next frame applies 4 entries over 4 consecutive cycles with busy high for 4 cycles.
REQ-038 The bench SHALL cover: 300 drops -> drop_count=255.
REQ-039 The bench SHALL cover: reset asserted in the 2nd drain cycle of a 3-entry snapshot -> all pos_out=128, FIFO empty, no further strobes.
REQ-040 The bench SHALL cover: a push arriving during A_DRAIN -> not applied until the following frame_start.
